// File: rtl/s641_resp_misr.sv
// Response compactor for the s641 core: folds 24 primary outputs per valid cycle
// into a Galois MISR and compares the final signature against a golden value.
module s641_resp_misr #(
   parameter int          WIDTH = 24,
   parameter logic [23:0] POLY  = 24'hC20001,
   parameter logic [23:0] SEED  = 24'h000000,
   parameter int          CNT_W = 16
) (
   input  logic             CK,
   input  logic             RST,
   input  logic             START,
   input  logic [CNT_W-1:0] NCYC,
   input  logic             RV,
   input  logic [WIDTH-1:0] RESP,
   input  logic [WIDTH-1:0] GOLDEN,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [WIDTH-1:0] SIG
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sig, sig_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   // One MISR step: logical left shift, feedback when the outgoing MSB is set.
   function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] resp);
      logic [WIDTH-1:0] fb;
      fb = cur[WIDTH-1] ? POLY[WIDTH-1:0] : '0;
      return (cur << 1) ^ fb ^ resp;
   endfunction

   always_ff @(posedge CK) begin
      if (RST) begin
         state <= S_IDLE;
         sig   <= SEED[WIDTH-1:0];
         cnt   <= '0;
      end else begin
         state <= state_nx;
         sig   <= sig_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      sig_nx   = sig;
      cnt_nx   = cnt;
      case (state)
         S_IDLE, S_DONE: begin
            if (START && (NCYC != '0)) begin
               state_nx = S_RUN;
               sig_nx   = SEED[WIDTH-1:0];
               cnt_nx   = NCYC;
            end
         end
         S_RUN: begin
            // START is deliberately ignored here; only valid responses advance the run.
            if (RV) begin
               sig_nx = misr_step(sig, RESP);
               cnt_nx = cnt - 1'b1;
               if (cnt == {{(CNT_W-1){1'b0}}, 1'b1})
                  state_nx = S_DONE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign BUSY = (state == S_RUN);
   assign DONE = (state == S_DONE);
   assign PASS = DONE && (sig == GOLDEN);
   assign SIG  = sig;

endmodule

// File: doc/s641_resp_misr.md
Name: s641_resp_misr

Overview:
- Output response compactor sitting directly downstream of the s641 core. It consumes the 24 primary outputs of s641 each clock and folds them into a 24-bit multiple-input signature register (MISR).
- A run is started by a handshake. After a programmed number of valid capture cycles, the final signature is compared against a golden value.
- Used in the benchmark self-test harness to turn s641 output streams into a single pass/fail verdict.

Parameters:
WIDTH, 24, response/signature width (matches s641 output count)
POLY, 24'hC20001, Galois feedback taps for x^24+x^23+x^22+x^17+1 (bit i = coefficient of x^i, x^24 implicit)
SEED, 24'h000000, signature value loaded at run start
CNT_W, 16, width of cycle-count programming

Ports:
CK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
START  in  1  run request, sampled in IDLE or DONE
NCYC  in  CNT_W  number of valid responses to compact; sampled with START
RV  in  1  response valid; RESP compacted only when RV=1
RESP  in  WIDTH  s641 outputs, bit order {G91,G94,G107,G83,G84,G85,G100BF,G98BF,G96BF,G92,G87BF,G89BF,G101BF,G106BF,G97BF,G104BF,G88BF,G99BF,G105BF,G138,G86BF,G95BF,G103BF,G90}, MSB first
GOLDEN  in  WIDTH  expected signature, compared combinationally
BUSY  out  1  high in RUN
DONE  out  1  high in DONE
PASS  out  1  DONE && (SIG == GOLDEN)
SIG  out  WIDTH  current signature register

Behaviour:
- Clocking and reset: one clock CK; reset is synchronous and active-high (RST).
- RST=1 at any edge, including mid-run:
  - next state IDLE; SIG=SEED; remaining count=0.
  - BUSY=0, DONE=0, PASS=0.
  - RST has priority over all other inputs.
- States:
  - IDLE: START=1 and NCYC!=0 -> RUN. START with NCYC=0 is ignored; remain IDLE.
  - RUN: see below.
  - DONE: DONE=1 and SIG frozen; held until RST or a restart. START=1 and NCYC!=0 -> RUN; otherwise stay.
- Run acceptance (on the accepting edge): SIG<=SEED; count<=NCYC.
- RUN, on each edge with RV=1:
  - SIG <= (SIG<<1) ^ (SIG[WIDTH-1] ? POLY : 0) ^ RESP.
  - count<=count-1.
  - If count was 1, next state DONE.
- RUN, RV=0: SIG and count hold; no timeout.
- START during RUN is ignored; NCYC changes after acceptance have no effect.
- Latency:
  - first compaction occurs on the edge after acceptance.
  - DONE rises on the edge that performs the NCYC-th valid compaction.
  - with continuous RV, the run takes exactly NCYC cycles in RUN.
- Arithmetic: shift is logical, bit 0 fill 0; all XORs modulo-2; count never wraps (maximum NCYC = 2^CNT_W-1).
- PASS is combinational and tracks GOLDEN while in DONE; it is 0 in IDLE and RUN regardless of SIG.
- SIG is visible in all states and updates only as above.

Test Plan:
- Reset, then START=1, NCYC=3, RV=1, RESP=0 for 3 cycles -> BUSY 3 cycles, DONE=1, SIG=000000; PASS=1 with GOLDEN=000000, PASS=0 with GOLDEN=000001.
- NCYC=2, RESP=800000 then 000000 -> SIG 800000 after 1st, C20001 after 2nd (feedback fired); DONE=1.
- NCYC=2, RESP=000001 with RV pattern 1,0,0,1 (second valid RESP=000000) -> SIG 000001, held 2 cycles, then 000002; DONE on 4th RUN cycle.
- START=1 with NCYC=0 in IDLE -> stays IDLE, BUSY=0, SIG unchanged; START pulses during RUN -> no restart, count unaffected.
- Assert RST on 2nd RUN cycle of an NCYC=5 run -> next cycle IDLE, SIG=SEED, BUSY=DONE=PASS=0.
- From DONE (SIG=C20001), START=1, NCYC=1, RESP=000005 -> reseed then SIG=000005, DONE again; PASS follows GOLDEN=000005.
